// File: rtl/alu_regfile_mc.sv
// Multi-cycle ALU over a small register file: IDLE/FETCH/EXEC/DONE sequencer,
// shift-add multiplier, direct load port and combinational read port.
module alu_regfile_mc #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ctrl,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] imm,
  input  logic [AW-1:0]    dst,
  input  logic             wr_en,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             z
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [WIDTH-1:0]   r_regs [NREGS];
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [AW-1:0]      r_dst;
  logic               r_wr_en;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH:0]     w_alu;
  logic               w_exec_last;
  logic [WIDTH-1:0]   w_opa;
  logic [WIDTH-1:0]   w_opb;
  logic               w_wb;
  logic [WIDTH-1:0]   r_y;
  logic               r_c;
  logic               r_z;
  logic               r_busy;
  logic               r_done;

  assign rd_data = r_regs[rd_addr];
  assign busy    = r_busy;
  assign done    = r_done;
  assign y       = r_y;
  assign c       = r_c;
  assign z       = r_z;

  // Operand selection and end-of-execution detection.
  always_comb begin
    w_opa       = r_regs[src_a];
    w_opb       = use_imm ? imm : r_regs[src_b];
    w_exec_last = (r_op != OP_MUL) || (r_cnt == CNT_LAST);
    w_wb        = (r_state == S_DONE) && r_wr_en;
  end

  // Next-state decode for the operation sequencer.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_exec_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result datapath; bit WIDTH of w_alu is the carry/borrow/overflow flag.
  always_comb begin
    w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
    w_alu     = {(WIDTH+1){1'b0}};
    case (r_op)
      OP_ADD:  w_alu = {1'b0, r_a} + {1'b0, r_b};
      OP_SUB:  w_alu = {1'b0, r_a} - {1'b0, r_b};
      OP_AND:  w_alu = {1'b0, r_a & r_b};
      OP_OR:   w_alu = {1'b0, r_a | r_b};
      OP_XOR:  w_alu = {1'b0, r_a ^ r_b};
      OP_MUL:  w_alu = {|w_acc_nxt[2*WIDTH-1:WIDTH], w_acc_nxt[WIDTH-1:0]};
      OP_SHL:  w_alu = {r_a, 1'b0};
      OP_SHR:  w_alu = {r_a[0], 1'b0, r_a[WIDTH-1:1]};
      default: w_alu = {(WIDTH+1){1'b0}};
    endcase
  end

  // Sequencer state and registered status/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= {WIDTH{1'b0}};
      r_c     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      if ((r_state == S_EXEC) && w_exec_last) begin
        r_y <= w_alu[WIDTH-1:0];
        r_c <= w_alu[WIDTH];
        r_z <= (w_alu[WIDTH-1:0] == {WIDTH{1'b0}});
      end
    end
  end

  // Operand capture at the FETCH edge and one partial product per MUL cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_ADD;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_dst    <= {AW{1'b0}};
      r_wr_en  <= 1'b0;
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else if (r_state == S_FETCH) begin
      r_op     <= ctrl;
      r_a      <= w_opa;
      r_b      <= w_opb;
      r_dst    <= dst;
      r_wr_en  <= wr_en;
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {{WIDTH{1'b0}}, w_opa};
      r_mplier <= w_opb;
      r_cnt    <= {CW{1'b0}};
    end else if (r_state == S_EXEC) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + CNT_ONE;
    end
  end

  // Register file: ALU writeback overrides a same-address direct load.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end else if (w_wb && (r_dst == AW'(i))) begin
        r_regs[i] <= r_y;
      end else if (ld_en && (ld_addr == AW'(i))) begin
        r_regs[i] <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_regfile_mc.sv
// Randomized and directed bench for alu_regfile_mc against a transaction-level
// timeline model of the register file and operation latency.
module tb_alu_regfile_mc;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int FAR = 1 << 30;

  logic          clk = 1'b0;
  logic          reset, start, use_imm, wr_en, ld_en;
  logic [2:0]    ctrl;
  logic [AW-1:0] src_a, src_b, dst, ld_addr, rd_addr;
  logic [W-1:0]  imm, ld_data, rd_data, y;
  logic          busy, done, c, z;

  alu_regfile_mc #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .ctrl(ctrl),
    .src_a(src_a), .src_b(src_b), .use_imm(use_imm), .imm(imm),
    .dst(dst), .wr_en(wr_en), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .y(y), .c(c), .z(z)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_regs [N];
  bit m_pend, m_busy, m_done, m_wr;
  int m_latch_e, m_done_e, m_dst, m_ry, m_rc, m_y, m_c, m_z;
  int e_cnt = 0;
  bit chk_en = 1'b0;

  // observations
  int done_count = 0;
  int last_done_e, last_y, last_c, last_z;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e_cnt);
    end
  endtask

  task automatic ref_alu(input int op, input int a, input int b, output int ry, output int rc);
    int mask, s;
    mask = (1 << W) - 1;
    case (op)
      0: begin s = a + b; ry = s & mask; rc = (s > mask) ? 1 : 0; end
      1: begin ry = (a - b) & mask; rc = (a < b) ? 1 : 0; end
      2: begin ry = a & b; rc = 0; end
      3: begin ry = a | b; rc = 0; end
      4: begin ry = a ^ b; rc = 0; end
      5: begin s = a * b; ry = s & mask; rc = (s > mask) ? 1 : 0; end
      6: begin ry = (a * 2) & mask; rc = (a >= (1 << (W - 1))) ? 1 : 0; end
      7: begin ry = a / 2; rc = a % 2; end
      default: begin ry = 0; rc = 0; end
    endcase
  endtask

  // Advance the model by one clock edge using the inputs applied at that edge.
  task automatic model_step();
    int nregs [N];
    bit was;
    int a, b;
    e_cnt++;
    if (reset) begin
      for (int i = 0; i < N; i++) m_regs[i] = 0;
      m_pend = 0; m_busy = 0; m_done = 0;
      m_y = 0; m_c = 0; m_z = 0;
      m_latch_e = FAR; m_done_e = FAR;
    end else begin
      was = m_pend;
      for (int i = 0; i < N; i++) nregs[i] = m_regs[i];
      if (ld_en) nregs[ld_addr] = int'(ld_data);
      if (was && e_cnt == m_latch_e) begin
        a = m_regs[src_a];
        b = use_imm ? int'(imm) : m_regs[src_b];
        ref_alu(int'(ctrl), a, b, m_ry, m_rc);
        m_dst = int'(dst);
        m_wr = wr_en;
        m_done_e = e_cnt + ((ctrl == 3'd5) ? W : 1);
      end
      if (was && e_cnt == m_done_e) begin
        m_y = m_ry; m_c = m_rc; m_z = (m_ry == 0) ? 1 : 0;
      end
      if (was && e_cnt == m_done_e + 1) begin
        if (m_wr) nregs[m_dst] = m_y;
        m_pend = 0;
      end
      if (!was && start) begin
        m_pend = 1;
        m_latch_e = e_cnt + 1;
        m_done_e = FAR;
      end
      for (int i = 0; i < N; i++) m_regs[i] = nregs[i];
      m_busy = m_pend;
      m_done = m_pend && (e_cnt == m_done_e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("y", 32'(y), 32'(m_y));
      chk("c", 32'(c), 32'(m_c));
      chk("z", 32'(z), 32'(m_z));
      chk("rd_data", 32'(rd_data), 32'(m_regs[rd_addr]));
      if (done === 1'b1) begin
        done_count++;
        last_done_e = e_cnt;
        last_y = int'(y); last_c = int'(c); last_z = int'(z);
      end
    end
  end

  task automatic load(input int a, input int d);
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = W'(d);
    tick();
    ld_en = 1'b0;
  endtask

  // Issue one operation and run until its done pulse has been seen.
  task automatic run_op(input int op, input int sa, input int sb, input int ui, input int im,
                        input int d, input int wr, input int xs_cyc, input int ld_cyc,
                        input int ld_a, input int ld_d, output int lat);
    int s, dc0, k;
    ctrl = 3'(op); src_a = AW'(sa); src_b = AW'(sb); use_imm = ui[0]; imm = W'(im);
    dst = AW'(d); wr_en = wr[0];
    start = 1'b1;
    s = e_cnt;
    dc0 = done_count;
    tick();
    start = 1'b0;
    k = 1;
    while (k < 40 && done_count == dc0) begin
      start = (k == xs_cyc);
      ld_en = (k == ld_cyc);
      ld_addr = AW'(ld_a);
      ld_data = W'(ld_d);
      tick();
      k++;
    end
    start = 1'b0;
    ld_en = 1'b0;
    chk("op_done_seen", 32'(done_count), 32'(dc0 + 1));
    lat = last_done_e - s;
  endtask

  initial begin
    int lat, dc;
    reset = 1'b1; start = 1'b0; ctrl = 3'd0; src_a = '0; src_b = '0; use_imm = 1'b0;
    imm = '0; dst = '0; wr_en = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    tick();
    tick();
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_y", 32'(y), 32'd0);
    reset = 1'b0;

    // ADD R0+R1 -> R2
    load(0, 2);
    load(1, 1);
    rd_addr = 2'd2;
    run_op(0, 0, 1, 0, 0, 2, 1, -1, -1, 0, 0, lat);
    chk("add_latency", 32'(lat), 32'd3);
    chk("add_y", 32'(last_y), 32'd3);
    chk("add_c", 32'(last_c), 32'd0);
    chk("add_z", 32'(last_z), 32'd0);
    #1 chk("add_rd", 32'(rd_data), 32'd3);

    // SUB R1-R0 borrows
    run_op(1, 1, 0, 0, 0, 0, 0, -1, -1, 0, 0, lat);
    chk("sub_y", 32'(last_y), 32'hf);
    chk("sub_c", 32'(last_c), 32'd1);
    chk("sub_z", 32'(last_z), 32'd0);

    // ADD R3=1111 + imm 1 wraps to zero
    load(3, 15);
    run_op(0, 3, 0, 1, 1, 0, 0, -1, -1, 0, 0, lat);
    chk("addi_y", 32'(last_y), 32'd0);
    chk("addi_c", 32'(last_c), 32'd1);
    chk("addi_z", 32'(last_z), 32'd1);

    // MUL 6*3 with an ignored start in cycle 2
    load(3, 6);
    dc = done_count;
    run_op(5, 3, 0, 1, 3, 0, 0, 2, -1, 0, 0, lat);
    chk("mul_latency", 32'(lat), 32'd6);
    chk("mul_y", 32'(last_y), 32'd2);
    chk("mul_c", 32'(last_c), 32'd1);
    repeat (8) tick();
    chk("mul_single_done", 32'(done_count), 32'(dc + 1));

    // Reset in the middle of MUL EXEC
    ctrl = 3'd5; src_a = 2'd3; use_imm = 1'b1; imm = 4'd3; dst = 2'd1; wr_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    dc = done_count;
    reset = 1'b1;
    start = 1'b1; ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'd9;
    tick();
    start = 1'b0; ld_en = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_y", 32'(y), 32'd0);
    chk("abort_cz", {30'd0, c, z}, 32'd0);
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      tick();
      chk("abort_reg", 32'(rd_data), 32'd0);
    end
    reset = 1'b0;
    repeat (8) tick();
    chk("abort_no_done", 32'(done_count), 32'(dc));

    // Load coinciding with writeback, and load to src_a during EXEC
    load(0, 2);
    load(1, 1);
    run_op(0, 0, 1, 0, 0, 2, 1, -1, 3, 2, 9, lat);
    rd_addr = 2'd2;
    #1 chk("wb_wins", 32'(rd_data), 32'd3);
    run_op(0, 0, 0, 1, 1, 1, 0, -1, 2, 0, 7, lat);
    chk("exec_load_y", 32'(last_y), 32'd3);
    rd_addr = 2'd0;
    #1 chk("exec_load_reg", 32'(rd_data), 32'd7);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset   = ($urandom_range(0, 79) == 0);
      start   = ($urandom_range(0, 2) == 0);
      ctrl    = 3'($urandom_range(0, 7));
      src_a   = AW'($urandom_range(0, N - 1));
      src_b   = AW'($urandom_range(0, N - 1));
      use_imm = 1'($urandom_range(0, 1));
      imm     = W'($urandom_range(0, 15));
      dst     = AW'($urandom_range(0, N - 1));
      wr_en   = 1'($urandom_range(0, 1));
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = AW'($urandom_range(0, N - 1));
      ld_data = W'($urandom_range(0, 15));
      rd_addr = AW'($urandom_range(0, N - 1));
      tick();
    end
    reset = 1'b0; start = 1'b0; ld_en = 1'b0;
    repeat (12) tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
